// File: rtl/pe_array_driver_pkg.sv
// =====================================================================
// pe_array_driver_pkg : shared widths and base type for the PE driver
// Revision 1.0
// =====================================================================
`default_nettype none

`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif
`ifndef BASE_W
`define BASE_W 2
`endif

package pe_array_driver_pkg;

    localparam int W      = `V_E_F_Bit;
    localparam int BASE_W = `BASE_W;

    typedef logic [BASE_W-1:0] base_t;

    localparam base_t BASE_NONE = '0;

endpackage

`default_nettype wire

// File: rtl/pe_array_driver_mymax.sv
// =====================================================================
// myMax : unsigned two-input maximum
// Revision 1.0
// =====================================================================
`default_nettype none

module myMax #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] max_o
);

    assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

`default_nettype wire

// File: rtl/pe_array_driver.sv
// =====================================================================
// pe_array_driver : sequences one query/target alignment run on a PE array
// Revision 1.0
// =====================================================================
`default_nettype none

module pe_array_driver
    import pe_array_driver_pkg::*;
#(
    parameter int PE_NUM = 8,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2*PE_NUM-1:0] query,
    input  logic [LEN_W-1:0]    query_len,
    input  logic                t_valid,
    output logic                t_ready,
    input  base_t               t_data,
    input  logic                t_last,
    output logic [PE_NUM-1:0]   arr_enable,
    output logic [2*PE_NUM-1:0] arr_s,
    output logic                arr_newLine,
    output base_t               arr_t,
    output logic [W-1:0]        arr_v,
    output logic [W-1:0]        arr_v_alpha,
    output logic [W-1:0]        arr_f,
    input  logic [W-1:0]        arr_result,
    output logic                busy,
    output logic                done,
    output logic [W-1:0]        score
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [2*PE_NUM-1:0] s_q, s_d;
    logic [PE_NUM-1:0]   mask_q, mask_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                first_q, first_d;
    logic [W-1:0]        score_q, score_d;

    logic                w_len_ok;
    logic                w_xfer;
    logic [PE_NUM-1:0]   w_mask_new;
    logic [W-1:0]        w_max;

    assign w_len_ok = (query_len != '0) && (query_len <= LEN_W'(PE_NUM));
    assign w_xfer   = (state_q == S_STREAM) && t_valid;

    always_comb begin
        w_mask_new = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            w_mask_new[i] = (LEN_W'(i) < query_len);
        end
    end

    myMax #(.W(W)) u_max (
        .a_i   (score_q),
        .b_i   (arr_result),
        .max_o (w_max)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = w_len_ok ? S_STREAM : S_DONE;
            S_STREAM: if (w_xfer && t_last) state_d = S_DRAIN;
            S_DRAIN:  if (cnt_q <= LEN_W'(1)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: the array only advances on transfer or drain cycles
    always_comb begin
        t_ready     = 1'b0;
        arr_enable  = '0;
        arr_t       = BASE_NONE;
        arr_newLine = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_STREAM: begin
                t_ready = 1'b1;
                busy    = 1'b1;
                if (w_xfer) begin
                    arr_enable  = mask_q;
                    arr_t       = t_data;
                    arr_newLine = first_q;
                end
            end
            S_DRAIN: begin
                busy       = 1'b1;
                arr_enable = mask_q;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        s_d     = s_q;
        mask_d  = mask_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        score_d = score_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    score_d = '0;
                    if (w_len_ok) begin
                        s_d     = query;
                        mask_d  = w_mask_new;
                        len_d   = query_len;
                        first_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (w_xfer) begin
                    first_d = 1'b0;
                    if (t_last) cnt_d = len_q;
                end
            end
            S_DRAIN: cnt_d = cnt_q - LEN_W'(1);
            default: ;
        endcase
        if (arr_enable != '0) score_d = w_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            mask_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            score_q <= '0;
        end else begin
            s_q     <= s_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            score_q <= score_d;
        end
    end

    assign arr_s       = s_q;
    assign score       = score_q;
    assign arr_v       = '0;
    assign arr_v_alpha = '0;
    assign arr_f       = '0;

endmodule

`default_nettype wire

// File: doc/pe_array_driver.md
PE_ARRAY_DRIVER -- requirements
Module: pe_array_driver

Interface
REQ-001 Parameter PE_NUM, default 8, number of processing elements in the driven array.
REQ-002 Parameter LEN_W, default 4, width of query_len; SHALL satisfy 2^LEN_W > PE_NUM.
REQ-003 Width W SHALL equal the shared V_E_F_Bit define.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active low.
REQ-007 start  in  1  begin a run; sampled in IDLE only.
REQ-008 query  in  2*PE_NUM  query bases, base i at bits [2i+1:2i].
REQ-009 query_len  in  LEN_W  number of valid query bases.
REQ-010 t_valid / t_ready  in / out  1 / 1  target stream handshake; a beat transfers when both are high.
REQ-011 t_data / t_last  in  2 / 1  target base and last-beat flag.
REQ-012 arr_enable  out  PE_NUM  per-PE enable to the array.
REQ-013 arr_s  out  2*PE_NUM  latched query to the array.
REQ-014 arr_newLine, arr_t  out  1, 2  row start flag and target base to the array head.
REQ-015 arr_v, arr_v_alpha, arr_f  out  W each  head boundary values.
REQ-016 arr_result  in  W  running maximum from the array.
REQ-017 busy, done, score  out  1, 1, W  run active; one-cycle completion pulse; best score.

Function
REQ-018 States: IDLE, STREAM, DRAIN, DONE.
REQ-019 In IDLE, t_ready=0 and arr_enable=0; start with 1<=query_len<=PE_NUM latches query and mask, clears score, and moves to STREAM.
REQ-020 In IDLE, start with query_len=0 or query_len>PE_NUM moves to DONE with score=0, and no beat is accepted.
REQ-021 Mask: bits [query_len-1:0] of arr_enable set, all other bits clear.
REQ-022 In STREAM, t_ready=1; on a transfer cycle arr_t=t_data and arr_enable=mask.
REQ-023 On a STREAM cycle with no transfer, arr_enable=0 (array frozen) and arr_t=0.
REQ-024 arr_newLine=1 only on the first transfer of a run, 0 on all other cycles.
REQ-025 arr_v, arr_v_alpha and arr_f SHALL be 0 at all times (local-alignment boundary).
REQ-026 A transfer with t_last=1 moves to DRAIN on the next edge.
REQ-027 In DRAIN, t_ready=0, arr_enable=mask, arr_t=0, and a counter runs exactly query_len cycles, then the state moves to DONE.
REQ-028 On every cycle in STREAM or DRAIN where arr_enable is nonzero, score <= unsigned max(score, arr_result).
REQ-029 DONE lasts one cycle with done=1, then returns to IDLE; score holds until the next accepted start.
REQ-030 busy=1 in STREAM and DRAIN, 0 otherwise.
REQ-031 start outside IDLE is ignored.
REQ-032 arr_s is registered and changes only on an accepted start.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, with every output 0 (t_ready, arr_*, busy, done, score) and counters cleared.
REQ-034 A reset during STREAM or DRAIN abandons the run; no done pulse follows.

Structure
REQ-035 The V_E_F_Bit width and the 2-bit base encoding SHALL come from the shared define file; state encoding stays local.
REQ-036 The score compare SHALL instantiate the existing myMax comparator; no new sub-module is needed.

Verification
REQ-037 Reset: assert rst_n=0 mid-STREAM -> all outputs 0 the same cycle, state IDLE, no done pulse.
REQ-038 start, query_len=3, PE_NUM=8 -> arr_enable=8'b0000_0111 on transfers; arr_s equals query.
REQ-039 4 beats with t_valid low on cycles 2 and 3 -> arr_enable=0 on gap cycles; arr_newLine high on the first transfer only.
REQ-040 t_last on beat 4 with query_len=3 -> exactly 3 DRAIN cycles, then a single done pulse; a stub driving arr_result 5, 9, 3 -> score=9.
REQ-041 start with query_len=0 -> done the next cycle with score=0; t_ready never high.
REQ-042 start asserted during DRAIN -> ignored; the run completes with the original query.
